// File: rtl/simon_pkg.sv
// Shared constants and state encoding for the SIMON32/64 key expansion.
package simon_pkg;

  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;

  // Symbol i of the z0 sequence lives at bit 61-i (leftmost character is bit 61).
  localparam logic [61:0]  Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [N-1:0] C  = 16'hFFFC;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rightCircShift.sv
// Fixed-amount right circular shift of a WIDTH-bit word.
module rightCircShift #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = (i_data >> SHIFT) | (i_data << (WIDTH - SHIFT));

endmodule

// File: rtl/simon_key_step.sv
// One SIMON32/64 key-expansion step: derives the next window word from w0, w1, w3 and z.
module simon_key_step
  import simon_pkg::*;
(
  input  logic [N-1:0] i_w0,
  input  logic [N-1:0] i_w1,
  input  logic [N-1:0] i_w3,
  input  logic         i_z,
  output logic [N-1:0] o_new
);

  logic [N-1:0] w_ror3;
  logic [N-1:0] w_tmp;
  logic [N-1:0] w_ror1;

  rightCircShift #(.WIDTH(N), .SHIFT(3)) u_ror3 (
    .i_data (i_w3),
    .o_data (w_ror3)
  );

  assign w_tmp = w_ror3 ^ i_w1;

  rightCircShift #(.WIDTH(N), .SHIFT(1)) u_ror1 (
    .i_data (w_tmp),
    .o_data (w_ror1)
  );

  assign o_new = C ^ {{(N-1){1'b0}}, i_z} ^ i_w0 ^ w_tmp ^ w_ror1;

endmodule

// File: rtl/simon_key_scheduler.sv
// Streams the 32 SIMON32/64 round keys over valid/ready from a latched 64-bit master key.
module simon_key_scheduler
  import simon_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [4*N-1:0] i_key,
  output logic           o_busy,
  output logic           o_rk_valid,
  input  logic           i_rk_ready,
  output logic [N-1:0]   o_rk_data,
  output logic [4:0]     o_rk_index,
  output logic           o_rk_last,
  output logic           o_done
);

  state_t       r_state;
  logic [N-1:0] r_w0, r_w1, r_w2, r_w3;
  logic [4:0]   r_index;
  logic         r_valid;
  logic         r_busy;
  logic         r_last;
  logic         r_done;

  logic         w_handshake;
  logic [5:0]   w_zIdx;
  logic         w_z;
  logic [N-1:0] w_new;

  assign w_handshake = r_valid & i_rk_ready;
  assign w_zIdx      = 6'd61 - {1'b0, r_index};
  assign w_z         = Z0[w_zIdx];

  simon_key_step u_step (
    .i_w0  (r_w0),
    .i_w1  (r_w1),
    .i_w3  (r_w3),
    .i_z   (w_z),
    .o_new (w_new)
  );

  // Abort takes priority over both start (in IDLE) and a same-cycle handshake (in RUN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_w0    <= i_key[N-1:0];
            r_w1    <= i_key[2*N-1:N];
            r_w2    <= i_key[3*N-1:2*N];
            r_w3    <= i_key[4*N-1:3*N];
            r_index <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_handshake) begin
            if (r_index == 5'(T-1)) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_w0    <= r_w1;
              r_w1    <= r_w2;
              r_w2    <= r_w3;
              r_w3    <= w_new;
              r_index <= r_index + 5'd1;
              r_last  <= (r_index == 5'(T-2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_rk_valid = r_valid;
  assign o_rk_data  = r_w0;
  assign o_rk_index = r_index;
  assign o_rk_last  = r_last;
  assign o_done     = r_done;

endmodule

// File: tb/tb_simon_key_scheduler.sv
// Directed and randomised-handshake bench for simon_key_scheduler against a software SIMON32/64 schedule.
module tb_simon_key_scheduler;

  localparam logic [63:0] KNOWN_KEY = 64'h1918_1110_0908_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rkReady = 1'b0;
  logic [63:0] key = '0;

  logic        busy;
  logic        rkValid;
  logic [15:0] rkData;
  logic [4:0]  rkIndex;
  logic        rkLast;
  logic        done;

  int nCompared = 0;
  int nMismatched = 0;

  logic [15:0] expKeys [32];
  logic [15:0] handTable [6];
  string       zSeq = "11111010001001010110000111001101111101000100101011000011100110";

  simon_key_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .i_key      (key),
    .o_busy     (busy),
    .o_rk_valid (rkValid),
    .i_rk_ready (rkReady),
    .o_rk_data  (rkData),
    .o_rk_index (rkIndex),
    .o_rk_last  (rkLast),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference schedule built in a flat array straight from the SIMON32/64 recurrence.
  function automatic void buildSchedule(input logic [63:0] k);
    logic [15:0] ks [32];
    logic [15:0] t;
    logic [15:0] zb;
    ks[0] = k[15:0];
    ks[1] = k[31:16];
    ks[2] = k[47:32];
    ks[3] = k[63:48];
    for (int j = 4; j < 32; j++) begin
      t  = {ks[j-1][2:0], ks[j-1][15:3]} ^ ks[j-3];
      zb = (zSeq[j-4] == "1") ? 16'h0001 : 16'h0000;
      ks[j] = 16'hFFFC ^ zb ^ ks[j-4] ^ t ^ {t[0], t[15:1]};
    end
    for (int j = 0; j < 32; j++) expKeys[j] = ks[j];
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " rk_valid"}, rkValid, 0);
    checkOutput({tag, " rk_data"}, rkData, 0);
    checkOutput({tag, " rk_index"}, rkIndex, 0);
    checkOutput({tag, " rk_last"}, rkLast, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  // readyMode: 0 always ready, 1 random ready, 2 stall five cycles at index 4.
  // startAt/abortAt/resetAt inject events at that key index (-1 disables); chain restarts in the done cycle.
  task automatic applyStimulus(input logic [63:0] k, input int readyMode, input int startAt,
                               input int abortAt, input int resetAt, input bit chain);
    int count;
    int cycles;
    int stall;
    bit isKnown;
    bit abortNow;
    bit hs;
    buildSchedule(k);
    isKnown = (k == KNOWN_KEY);
    key = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count = 0;
    cycles = 0;
    stall = 0;
    while (count < 32 && cycles < 400) begin
      case (readyMode)
        0: rkReady = 1'b1;
        1: rkReady = 1'($urandom_range(0, 1));
        default: begin
          rkReady = !(count == 4 && stall < 5);
          if (count == 4 && !rkReady) stall++;
        end
      endcase
      start = (count == startAt);
      key = (count == startAt) ? ~k : k;
      abortNow = (count == abortAt);
      abort = abortNow;
      @(negedge clk);
      checkOutput("rk_valid in run", rkValid, 1);
      checkOutput("busy in run", busy, 1);
      checkOutput("done in run", done, 0);
      checkOutput($sformatf("rk_data k%0d", count), rkData, expKeys[count]);
      checkOutput("rk_index", rkIndex, count);
      checkOutput("rk_last", rkLast, (count == 31));
      if (isKnown && count < 6) checkOutput($sformatf("hand vector k%0d", count), rkData, handTable[count]);
      if (count == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rkReady = 1'b0;
        start = 1'b0;
        key = k;
        return;
      end
      hs = rkReady && !abortNow;
      @(posedge clk); #1;
      start = 1'b0;
      key = k;
      if (abortNow) begin
        abort = 1'b0;
        checkOutput("abort rk_valid", rkValid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        @(posedge clk); #1;
        checkOutput("abort no done later", done, 0);
        checkOutput("abort stays idle", rkValid, 0);
        rkReady = 1'b0;
        return;
      end
      if (hs) count++;
      cycles++;
    end
    checkOutput("keys handed over", count, 32);
    if (readyMode == 0) checkOutput("cycles to done", cycles, 32);
    checkOutput("done pulse", done, 1);
    checkOutput("busy after done", busy, 0);
    checkOutput("rk_valid after done", rkValid, 0);
    if (chain) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("chain rk_valid", rkValid, 1);
      checkOutput("chain rk_data", rkData, expKeys[0]);
      checkOutput("chain rk_index", rkIndex, 0);
      checkOutput("chain done cleared", done, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("chain abort rk_valid", rkValid, 0);
    end else begin
      @(posedge clk); #1;
      checkOutput("done one cycle", done, 0);
    end
    rkReady = 1'b0;
  endtask

  initial begin
    handTable[0] = 16'h0100;
    handTable[1] = 16'h0908;
    handTable[2] = 16'h1110;
    handTable[3] = 16'h1918;
    handTable[4] = 16'h71C3;
    handTable[5] = 16'hB649;

    #1 rst_n = 1'b0;
    #2 checkAllZero("power-on reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkOutput("idle without start", rkValid, 0);

    start = 1'b1;
    abort = 1'b1;
    key = KNOWN_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort beats start valid", rkValid, 0);
    checkOutput("abort beats start busy", busy, 0);

    $display("[TB] known vector");
    applyStimulus(KNOWN_KEY, 0, -1, -1, -1, 1'b0);
    $display("[TB] backpressure at index 4");
    applyStimulus(KNOWN_KEY, 2, -1, -1, -1, 1'b0);
    $display("[TB] start during run, abort at index 10");
    applyStimulus(KNOWN_KEY, 0, 7, 10, -1, 1'b0);
    applyStimulus(KNOWN_KEY, 0, -1, -1, -1, 1'b0);
    $display("[TB] async reset at index 12");
    applyStimulus(KNOWN_KEY, 0, -1, -1, 12, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("post-reset idle valid", rkValid, 0);
      checkOutput("post-reset no done", done, 0);
    end
    @(posedge clk); #1;
    applyStimulus(KNOWN_KEY, 0, -1, -1, -1, 1'b1);

    $display("[TB] edge and random keys");
    applyStimulus(64'h0, 1, -1, -1, -1, 1'b0);
    applyStimulus({64{1'b1}}, 1, -1, -1, -1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus({$urandom, $urandom}, 1, -1, -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
